store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 176 +++++++++++++++++
 tb/tb_store_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: circular queue of issued stores that retire in order to the DCache.
// Younger loads read forwarded data from it or stall on a partial overlap.
module store_buffer #(
   parameter int DEPTH          = 4,
   parameter int MICROOP_WIDTH  = 5,
   parameter int ROB_INDEX_BITS = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      store_valid,
   input  logic [31:0]               store_address,
   input  logic [31:0]               store_data,
   input  logic [MICROOP_WIDTH-1:0]  store_microop,
   input  logic [ROB_INDEX_BITS-1:0] store_ticket,
   input  logic                      commit_valid,
   input  logic [ROB_INDEX_BITS-1:0] commit_ticket,
   input  logic                      flush,
   input  logic [31:0]               frw_address,
   input  logic [MICROOP_WIDTH-1:0]  frw_microop,
   output logic                      frw_valid,
   output logic [31:0]               frw_data,
   output logic                      frw_stall,
   output logic                      wr_valid,
   output logic [31:0]               wr_address,
   output logic [31:0]               wr_data,
   output logic [MICROOP_WIDTH-1:0]  wr_microop,
   input  logic                      wr_ready,
   output logic                      cache_writeback_valid,
   output logic                      sb_full,
   output logic                      sb_empty,
   output logic                      commit_error,
   output logic                      overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   typedef logic [PTR_W:0] ptr_t;

   ptr_t head_q, cmt_q, tail_q;
   ptr_t head_next, cmt_next, tail_next, count;
   logic [PTR_W-1:0] head_idx, cmt_idx, tail_idx, scan_idx;

   logic [DEPTH-1:0] valid_q, committed_q;
   logic [31:0]               addr_q   [DEPTH];
   logic [31:0]               data_q   [DEPTH];
   logic [MICROOP_WIDTH-1:0]  uop_q    [DEPTH];
   logic [ROB_INDEX_BITS-1:0] ticket_q [DEPTH];

   logic full_q, empty_q, cwb_q, cerr_q, ovf_q;
   logic enq, do_commit, deq, full_next;
   logic hit, exact;
   logic [31:0] hit_data;
   logic unused_frw_bits;

   function automatic logic [3:0] byte_mask(input logic [1:0] off, input logic [1:0] sz);
      logic [3:0] m;
      case (sz)
         2'b00:   m = 4'b0001;
         2'b01:   m = 4'b0011;
         default: m = 4'b1111;
      endcase
      return m << off;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] sz,
                                               input logic uns);
      logic signed [31:0] ext;
      case (sz)
         2'b00:   ext = uns ? {24'd0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
         2'b01:   ext = uns ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
         default: ext = d;
      endcase
      return ext;
   endfunction

   assign head_idx = head_q[PTR_W-1:0];
   assign cmt_idx  = cmt_q[PTR_W-1:0];
   assign tail_idx = tail_q[PTR_W-1:0];

   assign wr_valid   = (head_q != cmt_q) && committed_q[head_idx];
   assign wr_address = addr_q[head_idx];
   assign wr_data    = data_q[head_idx];
   assign wr_microop = uop_q[head_idx];

   assign sb_full               = full_q;
   assign sb_empty              = empty_q;
   assign cache_writeback_valid = cwb_q;
   assign commit_error          = cerr_q;
   assign overflow              = ovf_q;
   assign unused_frw_bits       = ^frw_microop;

   always_comb begin
      enq       = store_valid && !full_q && !flush;
      do_commit = commit_valid && (cmt_q != tail_q);
      deq       = wr_valid && wr_ready;
      cmt_next  = cmt_q + {{PTR_W{1'b0}}, do_commit};
      head_next = head_q + {{PTR_W{1'b0}}, deq};
      // A flush rolls the tail back to the commit point, including a commit made this cycle.
      tail_next = flush ? cmt_next : tail_q + {{PTR_W{1'b0}}, enq};
      full_next = (head_next[PTR_W] != tail_next[PTR_W]) &&
                  (head_next[PTR_W-1:0] == tail_next[PTR_W-1:0]);
   end

   // Walk oldest to youngest so the last overlapping entry seen decides the result.
   always_comb begin
      hit      = 1'b0;
      exact    = 1'b0;
      hit_data = '0;
      scan_idx = '0;
      count    = tail_q - head_q;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = head_idx + PTR_W'(i);
         if (ptr_t'(i) < count && valid_q[scan_idx] &&
             addr_q[scan_idx][31:2] == frw_address[31:2] &&
             |(byte_mask(addr_q[scan_idx][1:0], uop_q[scan_idx][1:0]) &
               byte_mask(frw_address[1:0], frw_microop[1:0]))) begin
            hit      = 1'b1;
            exact    = (addr_q[scan_idx] == frw_address) &&
                       (uop_q[scan_idx][1:0] == frw_microop[1:0]);
            hit_data = data_q[scan_idx];
         end
      end
      frw_valid = hit && exact;
      frw_stall = hit && !exact;
      frw_data  = (hit && exact) ? load_extend(hit_data, frw_microop[1:0], frw_microop[2]) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q      <= '0;
         cmt_q       <= '0;
         tail_q      <= '0;
         valid_q     <= '0;
         committed_q <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         cwb_q       <= 1'b0;
         cerr_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         head_q  <= head_next;
         cmt_q   <= cmt_next;
         tail_q  <= tail_next;
         full_q  <= full_next;
         empty_q <= (head_next == tail_next);
         cwb_q   <= deq;
         if (commit_valid && (!do_commit || ticket_q[cmt_idx] != commit_ticket))
            cerr_q <= 1'b1;
         if (store_valid && full_q && !flush)
            ovf_q <= 1'b1;
         for (int j = 0; j < DEPTH; j++) begin
            if (flush && valid_q[j] && !committed_q[j] && !(do_commit && cmt_idx == PTR_W'(j)))
               valid_q[j] <= 1'b0;
         end
         if (deq) begin
            valid_q[head_idx]     <= 1'b0;
            committed_q[head_idx] <= 1'b0;
         end
         if (do_commit)
            committed_q[cmt_idx] <= 1'b1;
         if (enq) begin
            valid_q[tail_idx]     <= 1'b1;
            committed_q[tail_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[tail_idx]   <= store_address;
         data_q[tail_idx]   <= store_data;
         uop_q[tail_idx]    <= store_microop;
         ticket_q[tail_idx] <= store_ticket;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: drain, forwarding, overflow,
// flush, ticket mismatch and reset during a stalled write.
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        store_valid;
   logic [31:0] store_address, store_data;
   logic [4:0]  store_microop;
   logic [2:0]  store_ticket;
   logic        commit_valid;
   logic [2:0]  commit_ticket;
   logic        flush;
   logic [31:0] frw_address;
   logic [4:0]  frw_microop;
   logic        frw_valid, frw_stall;
   logic [31:0] frw_data;
   logic        wr_valid;
   logic [31:0] wr_address, wr_data;
   logic [4:0]  wr_microop;
   logic        wr_ready;
   logic        cache_writeback_valid, sb_full, sb_empty, commit_error, overflow;

   int tests = 0;
   int fails = 0;

   store_buffer #(.DEPTH(4), .MICROOP_WIDTH(5), .ROB_INDEX_BITS(3)) dut (
      .clk(clk), .rst(rst),
      .store_valid(store_valid), .store_address(store_address), .store_data(store_data),
      .store_microop(store_microop), .store_ticket(store_ticket),
      .commit_valid(commit_valid), .commit_ticket(commit_ticket), .flush(flush),
      .frw_address(frw_address), .frw_microop(frw_microop),
      .frw_valid(frw_valid), .frw_data(frw_data), .frw_stall(frw_stall),
      .wr_valid(wr_valid), .wr_address(wr_address), .wr_data(wr_data), .wr_microop(wr_microop),
      .wr_ready(wr_ready), .cache_writeback_valid(cache_writeback_valid),
      .sb_full(sb_full), .sb_empty(sb_empty), .commit_error(commit_error), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [4:0] u,
                        input logic [2:0] t);
      store_valid   = 1'b1;
      store_address = a;
      store_data    = d;
      store_microop = u;
      store_ticket  = t;
      tick();
      store_valid = 1'b0;
   endtask

   task automatic commit(input logic [2:0] t);
      commit_valid  = 1'b1;
      commit_ticket = t;
      tick();
      commit_valid = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] a, input logic [4:0] u);
      frw_address = a;
      frw_microop = u;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; store_valid = 0; store_address = 0; store_data = 0; store_microop = 0;
      store_ticket = 0; commit_valid = 0; commit_ticket = 0; flush = 0;
      frw_address = 32'hFFFF_0000; frw_microop = 5'd2; wr_ready = 0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_empty", sb_empty, 1);
      check("rst_full", sb_full, 0);
      check("rst_wr_valid", wr_valid, 0);
      check("rst_cwb", cache_writeback_valid, 0);
      check("rst_frw_valid", frw_valid, 0);
      check("rst_frw_stall", frw_stall, 0);
      check("rst_commit_error", commit_error, 0);
      check("rst_overflow", overflow, 0);

      // Basic store -> commit -> drain
      store(32'h100, 32'hDEADBEEF, 5'd2, 3'd2);
      check("sw_not_empty", sb_empty, 0);
      check("sw_uncommitted_no_wr", wr_valid, 0);
      wr_ready = 1'b1;
      commit(3'd2);
      check("sw_wr_valid", wr_valid, 1);
      check("sw_wr_address", wr_address, 32'h100);
      check("sw_wr_data", wr_data, 32'hDEADBEEF);
      check("sw_wr_microop", wr_microop, 2);
      check("sw_no_commit_error", commit_error, 0);
      tick();
      check("sw_cwb_pulse", cache_writeback_valid, 1);
      check("sw_empty_after", sb_empty, 1);
      check("sw_wr_idle", wr_valid, 0);
      tick();
      check("sw_cwb_one_cycle", cache_writeback_valid, 0);

      // Byte store forwarding with sign/zero extension and partial overlap
      store(32'h203, 32'h0000_0080, 5'd0, 3'd3);
      lookup(32'h203, 5'd0);
      check("lb_valid", frw_valid, 1);
      check("lb_data", frw_data, 32'hFFFF_FF80);
      check("lb_no_stall", frw_stall, 0);
      lookup(32'h203, 5'd4);
      check("lbu_data", frw_data, 32'h0000_0080);
      lookup(32'h200, 5'd2);
      check("lw_partial_stall", frw_stall, 1);
      check("lw_partial_no_valid", frw_valid, 0);
      lookup(32'h300, 5'd2);
      check("miss_stall", frw_stall, 0);
      check("miss_valid", frw_valid, 0);
      check("miss_data", frw_data, 0);
      commit(3'd3);
      tick();
      check("sb_drained", sb_empty, 1);

      // Youngest of two matching stores wins
      store(32'h40, 32'h1, 5'd2, 3'd4);
      store(32'h40, 32'h2, 5'd2, 3'd5);
      lookup(32'h40, 5'd2);
      check("youngest_valid", frw_valid, 1);
      check("youngest_data", frw_data, 32'h2);
      commit(3'd4);
      commit(3'd5);
      tick();
      check("two_drained", sb_empty, 1);

      // Fill, overflow, then free one slot
      wr_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         store(32'h10 + 32'(4 * i), 32'(i), 5'd2, 3'(i));
      check("fill_full", sb_full, 1);
      check("fill_no_overflow", overflow, 0);
      store(32'h50, 32'h99, 5'd2, 3'd4);
      check("ovf_flag", overflow, 1);
      check("ovf_still_full", sb_full, 1);
      lookup(32'h50, 5'd2);
      check("ovf_dropped_no_fwd", frw_valid, 0);
      lookup(32'h18, 5'd2);
      check("full_fwd_data", frw_data, 32'h2);
      commit(3'd0);
      check("commit_not_drained_full", sb_full, 1);
      check("commit_wr_valid", wr_valid, 1);
      check("commit_wr_addr", wr_address, 32'h10);
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      check("drain_not_full", sb_full, 0);
      check("drain_cwb", cache_writeback_valid, 1);
      check("fill_no_commit_error", commit_error, 0);
      do_reset();
      check("reset_clears_overflow", overflow, 0);
      check("reset_empty", sb_empty, 1);

      // Flush drops uncommitted stores and ignores a same-cycle store
      store(32'h80, 32'hA, 5'd2, 3'd1);
      store(32'h84, 32'hB, 5'd2, 3'd2);
      store(32'h88, 32'hC, 5'd2, 3'd3);
      commit(3'd1);
      flush = 1'b1;
      store(32'h90, 32'hD, 5'd2, 3'd4);
      flush = 1'b0;
      lookup(32'h84, 5'd2);
      check("flush_miss_b", frw_valid, 0);
      lookup(32'h88, 5'd2);
      check("flush_miss_c", frw_valid, 0);
      lookup(32'h90, 5'd2);
      check("flush_store_ignored", frw_valid, 0);
      lookup(32'h80, 5'd2);
      check("flush_keeps_committed", frw_valid, 1);
      check("flush_committed_data", frw_data, 32'hA);
      check("flush_wr_addr", wr_address, 32'h80);
      check("flush_not_empty", sb_empty, 0);
      wr_ready = 1'b1;
      tick();
      check("flush_drain_cwb", cache_writeback_valid, 1);
      check("flush_empty_after", sb_empty, 1);
      lookup(32'h80, 5'd2);
      check("flush_lookup_miss", frw_valid, 0);
      tick();
      check("flush_no_more_writes", wr_valid, 0);

      // Ticket mismatch still commits and drains
      wr_ready = 1'b0;
      store(32'h60, 32'h55, 5'd2, 3'd1);
      commit(3'd4);
      check("mismatch_error", commit_error, 1);
      check("mismatch_wr_valid", wr_valid, 1);
      check("mismatch_wr_addr", wr_address, 32'h60);
      tick();
      check("stall_hold_valid", wr_valid, 1);
      check("stall_hold_data", wr_data, 32'h55);
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      check("mismatch_drained_cwb", cache_writeback_valid, 1);
      check("mismatch_drained_empty", sb_empty, 1);
      check("commit_error_sticky", commit_error, 1);

      // Commit with nothing outstanding
      do_reset();
      commit(3'd0);
      check("empty_commit_error", commit_error, 1);
      check("empty_commit_still_empty", sb_empty, 1);

      // Reset while a write is stalled
      store(32'h70, 32'h7, 5'd2, 3'd0);
      commit(3'd0);
      check("pre_reset_wr_valid", wr_valid, 1);
      rst = 1'b1;
      store_valid = 1'b1;
      commit_valid = 1'b1;
      tick();
      rst = 1'b0;
      store_valid = 1'b0;
      commit_valid = 1'b0;
      check("midrst_wr_valid", wr_valid, 0);
      check("midrst_empty", sb_empty, 1);
      check("midrst_full", sb_full, 0);
      check("midrst_commit_error", commit_error, 0);
      check("midrst_overflow", overflow, 0);
      check("midrst_cwb", cache_writeback_valid, 0);
      lookup(32'h70, 5'd2);
      check("midrst_frw_valid", frw_valid, 0);
      check("midrst_frw_stall", frw_stall, 0);
      tick();
      check("midrst_write_abandoned", wr_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
